// File: rtl/dual_issue_pkg.sv
// Shared definitions for the dual-issue pipeline writeback path.
//   DEFAULT_ADDR_W : default register address width
//   DEFAULT_DATA_W : default register data width
//   wb_entry_t     : one pending register write {dest, data} at default widths
package dual_issue_pkg;

  localparam int DEFAULT_ADDR_W = 5;
  localparam int DEFAULT_DATA_W = 32;

  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0] dest;
    logic [DEFAULT_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_pending_fifo.sv
// Circular pending-write queue: up to two pushes and one pop per cycle.
//   clk, reset       : clock, asynchronous active-low reset
//   push_cnt         : number of entries to push this cycle (0..2)
//   push_data[0..1]  : entries to push, oldest first
//   pop              : remove the head this cycle (only when count != 0)
//   head             : oldest entry
//   count            : occupancy
//   entry[i]         : i-th entry counted from the head (age order)
//   entry_valid[i]   : entry[i] holds a live write
module wb_pending_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       push_cnt,
  input  logic [W-1:0]     push_data [2],
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count,
  output logic [W-1:0]     entry [DEPTH],
  output logic [DEPTH-1:0] entry_valid
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  // Pointer advance modulo DEPTH (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p,
                                               input logic [PTR_W:0]   k);
    logic [PTR_W:0] s;
    s = {1'b0, p} + k;
    if (s >= (PTR_W+1)'(DEPTH)) s = s - (PTR_W+1)'(DEPTH);
    return s[PTR_W-1:0];
  endfunction

  always_comb begin
    rd_ptr_next = pop ? wrap_add(rd_ptr_reg, (PTR_W+1)'(1)) : rd_ptr_reg;
    wr_ptr_next = wrap_add(wr_ptr_reg, (PTR_W+1)'(push_cnt));
    count_next  = count_reg + CNT_W'(push_cnt) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage is not reset: liveness is carried entirely by count_reg.
  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0) mem[wr_ptr_reg] <= push_data[0];
    if (push_cnt == 2'd2) mem[wrap_add(wr_ptr_reg, (PTR_W+1)'(1))] <= push_data[1];
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

  // Present the contents in age order so the lookup can scan oldest to youngest.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign entry[gi]       = mem[wrap_add(rd_ptr_reg, (PTR_W+1)'(gi))];
    assign entry_valid[gi] = CNT_W'(gi) < count_reg;
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges the inst1/inst2 writeback streams onto the single register-file
// write port through an in-order pending queue, with a decode lookup port.
//   clk, reset                 : clock, asynchronous active-low reset
//   wb1_en/dest/data           : inst1 writeback (older)
//   wb2_en/dest/data           : inst2 writeback (younger)
//   stall                      : hold MEM/WB; inputs ignored while high
//   rf_we/rf_waddr/rf_wdata    : register-file write port (zeros when idle)
//   lk_addr_a/b                : decode lookup addresses
//   lk_hit_a/b, lk_data_a/b    : youngest pending/in-flight match
//   pending_cnt                : queue occupancy
module wb_write_arbiter
  import dual_issue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb1_en,
  input  logic [ADDR_W-1:0] wb1_dest,
  input  logic [DATA_W-1:0] wb1_data,
  input  logic              wb2_en,
  input  logic [ADDR_W-1:0] wb2_dest,
  input  logic [DATA_W-1:0] wb2_data,
  output logic              stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] lk_addr_a,
  input  logic [ADDR_W-1:0] lk_addr_b,
  output logic              lk_hit_a,
  output logic              lk_hit_b,
  output logic [DATA_W-1:0] lk_data_a,
  output logic [DATA_W-1:0] lk_data_b,
  output logic [CNT_W-1:0]  pending_cnt
);

  localparam int EW = ADDR_W + DATA_W;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t     e1, e2, rf_ent;
  logic       accept, c1_v, c2_v;
  logic [1:0] n_cand, push_cnt;
  logic       pop;
  logic [EW-1:0]    cand0, cand1;
  logic [EW-1:0]    push_data [2];
  logic [EW-1:0]    q_head;
  logic [CNT_W-1:0] q_count;
  logic [EW-1:0]    q_entry [DEPTH];
  logic [DEPTH-1:0] q_valid;

  assign e1 = '{dest: wb1_dest, data: wb1_data};
  assign e2 = '{dest: wb2_dest, data: wb2_data};

  // Stall depends on registered occupancy only; the queue is guaranteed room
  // for a worst-case cycle (+2 pushes, -1 pop) whenever stall is low.
  assign stall  = q_count >= CNT_W'(DEPTH - 1);
  // Gating with reset keeps the bypass path quiet while reset is held.
  assign accept = reset & ~stall;

  // Filtering: r0 writes vanish; on a same-dest pair the younger inst2 wins.
  assign c1_v = accept & wb1_en & (wb1_dest != '0) & ~(wb2_en & (wb2_dest == wb1_dest));
  assign c2_v = accept & wb2_en & (wb2_dest != '0);

  always_comb begin
    cand0  = c1_v ? e1 : e2;
    cand1  = e2;
    n_cand = {1'b0, c1_v} + {1'b0, c2_v};
  end

  // Queue empty: bypass the first candidate, queue the second.
  // Queue busy: drain the head, queue every candidate behind it.
  always_comb begin
    rf_ent       = '0;
    rf_we        = 1'b0;
    pop          = 1'b0;
    push_cnt     = 2'd0;
    push_data[0] = cand0;
    push_data[1] = cand1;
    if (q_count != '0) begin
      rf_we    = 1'b1;
      rf_ent   = q_head;
      pop      = 1'b1;
      push_cnt = n_cand;
    end else if (n_cand != 2'd0) begin
      rf_we        = 1'b1;
      rf_ent       = cand0;
      push_cnt     = n_cand - 2'd1;
      push_data[0] = cand1;
    end
  end

  assign rf_waddr    = rf_ent.dest;
  assign rf_wdata    = rf_ent.data;
  assign pending_cnt = q_count;

  wb_pending_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_cnt    (push_cnt),
    .push_data   (push_data),
    .pop         (pop),
    .head        (q_head),
    .count       (q_count),
    .entry       (q_entry),
    .entry_valid (q_valid)
  );

  // Scan oldest to youngest so the last match wins. The queue head covers the
  // in-flight write when the queue is busy; when it is empty the in-flight
  // write is one of this cycle's candidates.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] a);
    logic              hit;
    logic [DATA_W-1:0] data;
    hit  = 1'b0;
    data = '0;
    if (a != '0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q_valid[i] && (q_entry[i][EW-1 -: ADDR_W] == a)) begin
          hit  = 1'b1;
          data = q_entry[i][DATA_W-1:0];
        end
      end
      if (c1_v && (e1.dest == a)) begin
        hit  = 1'b1;
        data = e1.data;
      end
      if (c2_v && (e2.dest == a)) begin
        hit  = 1'b1;
        data = e2.data;
      end
    end
    return {hit, data};
  endfunction

  always_comb begin
    {lk_hit_a, lk_data_a} = lookup(lk_addr_a);
    {lk_hit_b, lk_data_b} = lookup(lk_addr_b);
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb1_en = 1'b0, wb2_en = 1'b0;
  logic [4:0]  wb1_dest = '0, wb2_dest = '0;
  logic [31:0] wb1_data = '0, wb2_data = '0;
  logic        stall, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  lk_addr_a = '0, lk_addr_b = '0;
  logic        lk_hit_a, lk_hit_b;
  logic [31:0] lk_data_a, lk_data_b;
  logic [2:0]  pending_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Every rf write observed outside reset, as {addr, data}.
  logic [36:0] rf_log [$];

  wb_write_arbiter #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .wb1_en(wb1_en), .wb1_dest(wb1_dest), .wb1_data(wb1_data),
    .wb2_en(wb2_en), .wb2_dest(wb2_dest), .wb2_data(wb2_data),
    .stall(stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .lk_addr_a(lk_addr_a), .lk_addr_b(lk_addr_b),
    .lk_hit_a(lk_hit_a), .lk_hit_b(lk_hit_b),
    .lk_data_a(lk_data_a), .lk_data_b(lk_data_b),
    .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset && rf_we) rf_log.push_back({rf_waddr, rf_wdata});
  end

  task automatic drive(input logic v1, input logic [4:0] d1, input logic [31:0] x1,
                       input logic v2, input logic [4:0] d2, input logic [31:0] x2);
    wb1_en = v1; wb1_dest = d1; wb1_data = x1;
    wb2_en = v2; wb2_dest = d2; wb2_data = x2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 5'd3, 32'h55, 1'b1, 5'd4, 32'h66);
    lk_addr_a = 5'd3;
    #12;
    n_checks++;
    if ({stall, rf_we, rf_waddr, rf_wdata, pending_cnt, lk_hit_a, lk_data_a} !== '0)
      $display("FAIL reset_outputs: got stall=%0b we=%0b addr=%0d data=%0h cnt=%0d hit=%0b ldata=%0h, expected all 0",
               stall, rf_we, rf_waddr, rf_wdata, pending_cnt, lk_hit_a, lk_data_a);
    else n_pass++;
    drive(0, 0, 0, 0, 0, 0);
    lk_addr_a = 0;
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    n_checks++;
    if ({stall, rf_we, pending_cnt} !== '0)
      $display("FAIL after_reset: got stall=%0b we=%0b cnt=%0d, expected 0 0 0", stall, rf_we, pending_cnt);
    else n_pass++;
  endtask

  task automatic test_single();
    drive(1'b1, 5'd3, 32'h11, 1'b0, 0, 0);
    lk_addr_a = 5'd3;
    @(negedge clk);
    n_checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h11})
      $display("FAIL single_bypass: got we=%0b r%0d=%0h, expected 1 r3=11", rf_we, rf_waddr, rf_wdata);
    else n_pass++;
    n_checks++;
    if ({lk_hit_a, lk_data_a} !== {1'b1, 32'h11})
      $display("FAIL single_lookup: got hit=%0b data=%0h, expected 1 11", lk_hit_a, lk_data_a);
    else n_pass++;
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    lk_addr_a = 0;
    n_checks++;
    if (pending_cnt !== 3'd0)
      $display("FAIL single_cnt: got %0d expected 0", pending_cnt);
    else n_pass++;
  endtask

  task automatic test_dual();
    drive(1'b1, 5'd4, 32'hA, 1'b1, 5'd5, 32'hB);
    lk_addr_a = 5'd5;
    lk_addr_b = 5'd4;
    @(negedge clk);
    n_checks++;
    if ({rf_we, rf_waddr, rf_wdata, pending_cnt, stall} !== {1'b1, 5'd4, 32'hA, 3'd0, 1'b0})
      $display("FAIL dual_c0: got we=%0b r%0d=%0h cnt=%0d stall=%0b, expected 1 r4=a 0 0",
               rf_we, rf_waddr, rf_wdata, pending_cnt, stall);
    else n_pass++;
    n_checks++;
    if ({lk_hit_a, lk_data_a, lk_hit_b, lk_data_b} !== {1'b1, 32'hB, 1'b1, 32'hA})
      $display("FAIL dual_lookup: got a=%0b/%0h b=%0b/%0h, expected 1/b 1/a",
               lk_hit_a, lk_data_a, lk_hit_b, lk_data_b);
    else n_pass++;
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if ({rf_we, rf_waddr, rf_wdata, pending_cnt, stall} !== {1'b1, 5'd5, 32'hB, 3'd1, 1'b0})
      $display("FAIL dual_c1: got we=%0b r%0d=%0h cnt=%0d stall=%0b, expected 1 r5=b 1 0",
               rf_we, rf_waddr, rf_wdata, pending_cnt, stall);
    else n_pass++;
    n_checks++;
    if ({lk_hit_a, lk_data_a, lk_hit_b} !== {1'b1, 32'hB, 1'b0})
      $display("FAIL dual_lookup_c1: got a=%0b/%0h b=%0b, expected 1/b 0", lk_hit_a, lk_data_a, lk_hit_b);
    else n_pass++;
    next_cycle();
    lk_addr_a = 0;
    lk_addr_b = 0;
    @(negedge clk);
    n_checks++;
    if ({rf_we, rf_waddr, rf_wdata, pending_cnt, stall} !== '0)
      $display("FAIL dual_idle: got we=%0b r%0d=%0h cnt=%0d stall=%0b, expected all 0",
               rf_we, rf_waddr, rf_wdata, pending_cnt, stall);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_collision();
    rf_log.delete();
    drive(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2);
    @(negedge clk);
    n_checks++;
    if ({rf_we, rf_waddr, rf_wdata, pending_cnt} !== {1'b1, 5'd7, 32'h2, 3'd0})
      $display("FAIL collision_c0: got we=%0b r%0d=%0h cnt=%0d, expected 1 r7=2 0",
               rf_we, rf_waddr, rf_wdata, pending_cnt);
    else n_pass++;
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    next_cycle();
    n_checks++;
    if (rf_log.size() != 1 || pending_cnt !== 3'd0)
      $display("FAIL collision_count: got %0d writes cnt=%0d, expected 1 write cnt=0", rf_log.size(), pending_cnt);
    else n_pass++;
  endtask

  task automatic test_dest_zero();
    rf_log.delete();
    drive(1'b1, 5'd0, 32'hFF, 1'b1, 5'd9, 32'h9);
    lk_addr_a = 5'd0;
    lk_addr_b = 5'd9;
    @(negedge clk);
    n_checks++;
    if ({rf_we, rf_waddr, rf_wdata, pending_cnt} !== {1'b1, 5'd9, 32'h9, 3'd0})
      $display("FAIL zero_c0: got we=%0b r%0d=%0h cnt=%0d, expected 1 r9=9 0",
               rf_we, rf_waddr, rf_wdata, pending_cnt);
    else n_pass++;
    n_checks++;
    if ({lk_hit_a, lk_data_a, lk_hit_b, lk_data_b} !== {1'b0, 32'h0, 1'b1, 32'h9})
      $display("FAIL zero_lookup: got a=%0b/%0h b=%0b/%0h, expected 0/0 1/9",
               lk_hit_a, lk_data_a, lk_hit_b, lk_data_b);
    else n_pass++;
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    lk_addr_b = 0;
    next_cycle();
    n_checks++;
    if (rf_log.size() != 1)
      $display("FAIL zero_count: got %0d writes expected 1", rf_log.size());
    else n_pass++;
  endtask

  task automatic test_saturation();
    logic [4:0]  pd1 [8];
    logic [4:0]  pd2 [8];
    logic [36:0] expw [$];
    int k, cyc, exp_cnt, waited;
    logic exp_stall;
    rf_log.delete();
    for (int i = 0; i < 8; i++) begin
      pd1[i] = 5'(10 + 2 * i);
      pd2[i] = 5'(11 + 2 * i);
    end
    // Last pair rewrites r23 (queued by pair 6) and uses r24.
    pd1[7] = 5'd24;
    pd2[7] = 5'd23;
    for (int i = 0; i < 8; i++) begin
      expw.push_back({pd1[i], 32'h100 + 32'(i * 16)});
      expw.push_back({pd2[i], 32'h101 + 32'(i * 16)});
    end
    k = 0; cyc = 0; exp_cnt = 0;
    while (k < 8 && cyc < 40) begin
      drive(1'b1, pd1[k], 32'h100 + 32'(k * 16), 1'b1, pd2[k], 32'h101 + 32'(k * 16));
      exp_stall = (exp_cnt >= 3);
      @(negedge clk);
      n_checks++;
      if (stall !== exp_stall || pending_cnt !== 3'(exp_cnt) || pending_cnt > 3'd4)
        $display("FAIL sat_cycle%0d: got stall=%0b cnt=%0d, expected stall=%0b cnt=%0d",
                 cyc, stall, pending_cnt, exp_stall, exp_cnt);
      else n_pass++;
      if (exp_stall) exp_cnt = exp_cnt - 1;
      else if (exp_cnt == 0) exp_cnt = 1;
      else exp_cnt = exp_cnt + 1;
      next_cycle();
      if (!exp_stall) k++;
      cyc++;
    end
    drive(0, 0, 0, 0, 0, 0);
    lk_addr_a = 5'd23;
    lk_addr_b = 5'd22;
    @(negedge clk);
    n_checks++;
    if ({lk_hit_a, lk_data_a, lk_hit_b, pending_cnt} !== {1'b1, 32'h171, 1'b0, 3'd3})
      $display("FAIL sat_lookup: got a=%0b/%0h b=%0b cnt=%0d, expected 1/171 0 3",
               lk_hit_a, lk_data_a, lk_hit_b, pending_cnt);
    else n_pass++;
    lk_addr_a = 0;
    lk_addr_b = 0;
    waited = 0;
    while (pending_cnt != 0 && waited < 20) begin
      next_cycle();
      waited++;
    end
    next_cycle();
    n_checks++;
    if (pending_cnt !== 3'd0)
      $display("FAIL sat_drain: got cnt=%0d expected 0 within 20 cycles", pending_cnt);
    else n_pass++;
    n_checks++;
    if (rf_log.size() != expw.size())
      $display("FAIL sat_write_count: got %0d expected %0d", rf_log.size(), expw.size());
    else n_pass++;
    for (int i = 0; i < expw.size() && i < rf_log.size(); i++) begin
      n_checks++;
      if (rf_log[i] !== expw[i])
        $display("FAIL sat_order%0d: got r%0d=%0h expected r%0d=%0h",
                 i, rf_log[i][36:32], rf_log[i][31:0], expw[i][36:32], expw[i][31:0]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    rf_log.delete();
    drive(1'b1, 5'd26, 32'hA6, 1'b1, 5'd27, 32'hA7);
    next_cycle();
    drive(1'b1, 5'd28, 32'hA8, 1'b1, 5'd29, 32'hA9);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (pending_cnt !== 3'd2)
      $display("FAIL midrst_pre: got cnt=%0d expected 2", pending_cnt);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({pending_cnt, stall, rf_we, rf_waddr, rf_wdata} !== '0)
      $display("FAIL midrst_cleared: got cnt=%0d stall=%0b we=%0b r%0d=%0h, expected all 0",
               pending_cnt, stall, rf_we, rf_waddr, rf_wdata);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    reset = 1'b1;
    repeat (4) next_cycle();
    n_checks++;
    if (rf_log.size() != 2 || rf_log[0] !== {5'd26, 32'hA6} || rf_log[1] !== {5'd27, 32'hA7})
      $display("FAIL midrst_log: got %0d writes, expected exactly r26=a6 then r27=a7", rf_log.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_collision();
    test_dest_zero();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Merges the two per-cycle writeback streams of the dual-issue pipeline (inst1 and inst2 MEM/WB outputs) onto the register file's single write port. Sits between the two MEM/WB pipeline registers and the register file. Keeps a small in-order pending-write queue, stalls the pipeline when the queue cannot absorb a worst-case cycle, and exposes a lookup port so decode can see values that are not yet written.

## Interface
Parameters:
- DEPTH, 4, pending-queue entries; must be ≥ 2.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- wb1_en  in  1  inst1 writeback valid (RegWriteEn of inst1 at WB).
- wb1_dest  in  ADDR_W  inst1 destination register.
- wb1_data  in  DATA_W  inst1 write data.
- wb2_en  in  1  inst2 writeback valid; inst2 is younger than inst1.
- wb2_dest  in  ADDR_W  inst2 destination register.
- wb2_data  in  DATA_W  inst2 write data.
- stall  out  1  freezes the MEM/WB registers; inputs are ignored in any cycle where stall=1.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  ADDR_W  register-file write address.
- rf_wdata  out  DATA_W  register-file write data.
- lk_addr_a, lk_addr_b  in  ADDR_W  decode lookup addresses.
- lk_hit_a, lk_hit_b  out  1  a pending or in-flight write matches the address.
- lk_data_a, lk_data_b  out  DATA_W  data of the youngest match; 0 when there is no hit.
- pending_cnt  out  $clog2(DEPTH+1)  queue occupancy.

## Operation
- Input filtering in accepted cycles (stall=0):
  - A write with dest=0 is discarded.
  - If both writes are valid with the same nonzero dest, only wb2 is kept (younger wins).
  - The result is 0, 1 or 2 ordered candidate writes, inst1 before inst2.
- Queue empty:
  - The first candidate goes straight to the rf port in the same cycle (combinational bypass).
  - The second candidate, if any, is enqueued.
- Queue non-empty:
  - The head drains to the rf port.
  - All candidates are enqueued behind it.
  - Program order is preserved.
- stall=1: inputs are ignored and the head still drains. Upstream holds and re-presents its writes.
- Lookup:
  - Searches the candidate currently on the rf port, all queue entries and the accepted candidates of this cycle.
  - The youngest match wins.
  - Address 0 never hits.
- rf_we=0 when nothing is to be written. rf_waddr and rf_wdata are 0 in that case.

## Timing
- All outputs are 0 while reset is asserted and after reset. Queue is emptied and stall=0.
- Reset mid-operation discards queued writes; this is intentional.
- Bypass latency is 0 cycles. A queued write is written N cycles later, where N is its position counting the head as 1.
- stall = (DEPTH − pending_cnt) < 2, computed from registered occupancy only. stall has no combinational path from the wb* inputs.
- Next occupancy = pending_cnt + enqueued − drained, where drained ∈ {0,1}. Overflow is impossible by construction; the bench asserts this.
- Read and write pointers wrap modulo DEPTH.
- Full-rate case: continuous dual writes to distinct registers settle to a 1-stall-in-2 pattern.

## Structure
- Shared package dual_issue_pkg holds:
  - ADDR_W and DATA_W defaults.
  - The wb_entry_t struct {dest, data}.
- Sub-module wb_pending_fifo: a circular queue with 2-push/1-pop per cycle, head/count outputs, and an entry array exposed for the lookup search.
- The arbiter top contains filtering, the bypass mux, stall generation and the lookup priority search.

## Test plan
- Single write, queue empty: wb1 r3=0x11 → rf_we=1, r3, 0x11 in the same cycle; pending_cnt stays 0.
- Dual write to distinct registers: r4=0xA and r5=0xB → cycle 0 writes r4; cycle 1 writes r5; pending_cnt 1 then 0; stall stays 0.
- Same-destination collision: both r7, wb1=0x1, wb2=0x2 → exactly one write, r7=0x2.
- Dest-zero suppression: wb1 r0=0xFF with wb2 r9=0x9 → only r9 is written, in the same cycle; lk_addr_a=0 gives no hit.
- Saturation with DEPTH=4: dual distinct writes every accepted cycle →
  - stall rises once pending_cnt=3.
  - All writes reach the rf in input order with no loss.
  - No overflow.
  - Lookup of a queued register returns the youngest value.
- Reset mid-run with pending_cnt=2:
  - Drop reset → pending_cnt=0, stall=0, rf_we=0.
  - Queued writes never appear on the rf port.
